decode_execute_unit: RTL and testbench

RV32I-subset decode plus execute stage of the 5-stage pipeline. It splits the fetched instruction into fields and immediates, generates control signals, selects ALU operands and evaluates the branch condition. Results are captured in the EX/MEM pipeline register. Combinational register addresses go to the register file; registered outputs go to the memory unit and to the PC logic.

---
 rtl/decode_execute_unit.sv | 215 +++++++++++++++++++++
 tb/tb_decode_execute_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// RV32I-subset decode + execute stage: field/immediate decode, control generation,
// ALU and BEQ evaluation, captured in the EX/MEM pipeline register.
module decode_execute_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_link,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_load,
    output logic            ex_store,
    output logic            ex_branch_taken,
    output logic            ex_jump,
    output logic [6:0]      ex_opcode
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_sel_e;

    // SRA/SRAI deliberately collapse onto SRL; SLTU is treated as signed SLT.
    function automatic alu_sel_e funct_to_alu(input logic [2:0] f3, input logic is_sub);
        alu_sel_e sel;
        case (f3)
            3'b000:  sel = is_sub ? ALU_SUB : ALU_ADD;
            3'b111:  sel = ALU_AND;
            3'b110:  sel = ALU_OR;
            3'b100:  sel = ALU_XOR;
            3'b001:  sel = ALU_SLL;
            3'b101:  sel = ALU_SRL;
            default: sel = ALU_SLT;
        endcase
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] alu_exec(input alu_sel_e sel,
                                                input logic signed [XLEN-1:0] a,
                                                input logic signed [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (sel)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_SLL: r = $unsigned(a) << b[4:0];
            ALU_SRL: r = $unsigned(a) >> b[4:0];
            default: r = {{(XLEN-1){1'b0}}, (a < b)};
        endcase
        return r;
    endfunction

    // ---- Stage p0: decode and execute (combinational) ----
    logic [6:0]             opcode_p0;
    logic [4:0]             rd_p0;
    logic [2:0]             funct3_p0;
    logic signed [XLEN-1:0] imm_i_p0;
    logic signed [XLEN-1:0] imm_s_p0;
    logic signed [XLEN-1:0] imm_b_p0;
    logic signed [XLEN-1:0] imm_j_p0;
    logic signed [XLEN-1:0] op1_p0;
    logic signed [XLEN-1:0] op2_p0;
    alu_sel_e               alu_sel_p0;
    logic                   vld_p0;
    logic                   reg_write_p0;
    logic                   load_p0;
    logic                   store_p0;
    logic                   branch_taken_p0;
    logic                   jump_p0;
    logic [XLEN-1:0]        result_p0;

    assign opcode_p0 = instr[6:0];
    assign rd_p0     = instr[11:7];
    assign funct3_p0 = instr[14:12];
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];

    assign imm_i_p0 = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s_p0 = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_p0 = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
    assign imm_j_p0 = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};

    always_comb begin
        op1_p0          = rs1_data;
        op2_p0          = rs2_data;
        alu_sel_p0      = ALU_ADD;
        vld_p0          = 1'b1;
        reg_write_p0    = 1'b0;
        load_p0         = 1'b0;
        store_p0        = 1'b0;
        branch_taken_p0 = 1'b0;
        jump_p0         = 1'b0;
        case (opcode_p0)
            OP_R: begin
                alu_sel_p0   = funct_to_alu(funct3_p0, instr[30]);
                reg_write_p0 = 1'b1;
            end
            OP_IMM: begin
                op2_p0       = imm_i_p0;
                alu_sel_p0   = funct_to_alu(funct3_p0, 1'b0);
                reg_write_p0 = 1'b1;
            end
            OP_LOAD: begin
                op2_p0       = imm_i_p0;
                load_p0      = 1'b1;
                reg_write_p0 = 1'b1;
            end
            OP_STORE: begin
                op2_p0   = imm_s_p0;
                store_p0 = 1'b1;
            end
            OP_BR: begin
                op1_p0          = pc;
                op2_p0          = imm_b_p0;
                branch_taken_p0 = (funct3_p0 == 3'b000) && (rs1_data == rs2_data);
            end
            OP_JAL: begin
                op1_p0       = pc;
                op2_p0       = imm_j_p0;
                jump_p0      = 1'b1;
                reg_write_p0 = 1'b1;
            end
            default: vld_p0 = 1'b0;
        endcase
    end

    assign result_p0 = vld_p0 ? alu_exec(alu_sel_p0, op1_p0, op2_p0) : '0;

    // ---- Stage p1: EX/MEM register ----
    logic [XLEN-1:0] result_p1;
    logic [XLEN-1:0] store_data_p1;
    logic [XLEN-1:0] link_p1;
    logic [4:0]      rd_p1;
    logic            reg_write_p1;
    logic            load_p1;
    logic            store_p1;
    logic            branch_taken_p1;
    logic            jump_p1;
    logic [6:0]      opcode_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1       <= '0;
            store_data_p1   <= '0;
            link_p1         <= '0;
            rd_p1           <= '0;
            reg_write_p1    <= 1'b0;
            load_p1         <= 1'b0;
            store_p1        <= 1'b0;
            branch_taken_p1 <= 1'b0;
            jump_p1         <= 1'b0;
            opcode_p1       <= '0;
        end else begin
            result_p1     <= result_p0;
            store_data_p1 <= rs2_data;
            link_p1       <= pc + XLEN'(4);
            if (flush) begin
                rd_p1           <= '0;
                reg_write_p1    <= 1'b0;
                load_p1         <= 1'b0;
                store_p1        <= 1'b0;
                branch_taken_p1 <= 1'b0;
                jump_p1         <= 1'b0;
                opcode_p1       <= '0;
            end else begin
                rd_p1           <= rd_p0;
                // x0 is hardwired, so never request a write to it.
                reg_write_p1    <= reg_write_p0 && (rd_p0 != 5'd0);
                load_p1         <= load_p0;
                store_p1        <= store_p0;
                branch_taken_p1 <= branch_taken_p0;
                jump_p1         <= jump_p0;
                opcode_p1       <= opcode_p0;
            end
        end
    end

    assign ex_result       = result_p1;
    assign ex_store_data   = store_data_p1;
    assign ex_link         = link_p1;
    assign ex_rd           = rd_p1;
    assign ex_reg_write    = reg_write_p1;
    assign ex_load         = load_p1;
    assign ex_store        = store_p1;
    assign ex_branch_taken = branch_taken_p1;
    assign ex_jump         = jump_p1;
    assign ex_opcode       = opcode_p1;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Self-checking bench for decode_execute_unit: directed cases plus randomized
// back-to-back traffic compared against an instruction-level reference model.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [31:0] ex_link;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_load;
    logic        ex_store;
    logic        ex_branch_taken;
    logic        ex_jump;
    logic [6:0]  ex_opcode;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_execute_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_link(ex_link),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_load(ex_load),
        .ex_store(ex_store), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .ex_opcode(ex_opcode)
    );

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [31:0] link;
        logic [4:0]  rd;
        logic        reg_write;
        logic        load;
        logic        store;
        logic        taken;
        logic        jump;
        logic [6:0]  opcode;
    } out_t;

    out_t act;
    assign act = {ex_result, ex_store_data, ex_link, ex_rd, ex_reg_write, ex_load,
                  ex_store, ex_branch_taken, ex_jump, ex_opcode};

    // Reference ALU expressed directly from the RV32I funct3 meaning.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub,
                                            input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000: return sub ? a - b : a + b;
            3'b111: return a & b;
            3'b110: return a | b;
            3'b100: return a ^ b;
            3'b001: return a << b[4:0];
            3'b101: return a >> b[4:0];
            default: return (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic out_t ref_model(input logic [31:0] ins, input logic [31:0] p,
                                       input logic [31:0] a, input logic [31:0] b);
        out_t o;
        int signed imm_i, imm_s, imm_b, imm_j;
        logic [12:0] braw;
        logic [20:0] jraw;
        imm_i = $signed(ins[31:20]);
        imm_s = $signed({ins[31:25], ins[11:7]});
        braw  = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        jraw  = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_b = $signed(braw);
        imm_j = $signed(jraw);
        o = '0;
        o.rd = ins[11:7];
        o.opcode = ins[6:0];
        o.store_data = b;
        o.link = p + 32'd4;
        case (ins[6:0])
            7'h33: begin o.result = ref_alu(ins[14:12], ins[30], a, b); o.reg_write = 1; end
            7'h13: begin o.result = ref_alu(ins[14:12], 1'b0, a, imm_i); o.reg_write = 1; end
            7'h03: begin o.result = a + imm_i; o.load = 1; o.reg_write = 1; end
            7'h23: begin o.result = a + imm_s; o.store = 1; end
            7'h63: begin o.result = p + imm_b; o.taken = (ins[14:12] == 3'b000) && (a == b); end
            7'h6F: begin o.result = p + imm_j; o.jump = 1; o.reg_write = 1; end
            default: o.result = 32'd0;
        endcase
        if (o.rd == 5'd0) o.reg_write = 0;
        return o;
    endfunction

    // Present one set of inputs for one clock and return just after the edge.
    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input logic r);
        @(negedge clk);
        instr = i; pc = p; rs1_data = a; rs2_data = b; flush = fl; rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b1);
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_initial: got %h expected 0", act);
        end
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        drive(32'h002081B3, 32'h10, 32'd5, 32'd7, 1'b1, 1'b1);
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL reset_over_add_flush: got %h expected 0", act);
        end
    endtask

    task automatic test_alu();
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_rd, ex_reg_write, ex_load, ex_store, ex_jump, ex_branch_taken}
            !== {32'd12, 5'd3, 1'b1, 4'b0000}) begin
            failures++;
            $display("FAIL add: result=%h rd=%0d rw=%b ld=%b st=%b j=%b br=%b expected 12 rd=3 rw=1 others 0",
                     ex_result, ex_rd, ex_reg_write, ex_load, ex_store, ex_jump, ex_branch_taken);
        end
        drive(32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
        checks++;
        if (ex_result !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL sub: got %h expected fffffffe", ex_result);
        end
        drive(32'hFFF00093, 32'h0, 32'd0, 32'd3, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_rd, ex_reg_write} !== {32'hFFFFFFFF, 5'd1, 1'b1}) begin
            failures++;
            $display("FAIL addi: result=%h rd=%0d rw=%b expected ffffffff rd=1 rw=1",
                     ex_result, ex_rd, ex_reg_write);
        end
    endtask

    task automatic test_store();
        drive(32'h0020A423, 32'h0, 32'h100, 32'hDEAD, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_store_data, ex_store, ex_reg_write, ex_load}
            !== {32'h108, 32'hDEAD, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sw: result=%h sdata=%h st=%b rw=%b ld=%b expected 108 dead 1 0 0",
                     ex_result, ex_store_data, ex_store, ex_reg_write, ex_load);
        end
    endtask

    task automatic test_branch();
        drive(32'h00208863, 32'h40, 32'd9, 32'd9, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_branch_taken, ex_reg_write} !== {32'h50, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL beq_taken: result=%h taken=%b rw=%b expected 50 1 0",
                     ex_result, ex_branch_taken, ex_reg_write);
        end
        drive(32'h00208863, 32'h40, 32'd9, 32'd8, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_branch_taken} !== {32'h50, 1'b0}) begin
            failures++;
            $display("FAIL beq_not_taken: result=%h taken=%b expected 50 0",
                     ex_result, ex_branch_taken);
        end
        // bne encoding with equal operands must still report not-taken
        drive(32'h00209863, 32'h40, 32'd9, 32'd9, 1'b0, 1'b0);
        checks++;
        if (ex_branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL bne_equal: taken=%b expected 0", ex_branch_taken);
        end
    endtask

    task automatic test_jal();
        drive(32'h008000EF, 32'h20, 32'd1, 32'd2, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_link, ex_jump, ex_reg_write, ex_rd}
            !== {32'h28, 32'h24, 1'b1, 1'b1, 5'd1}) begin
            failures++;
            $display("FAIL jal: result=%h link=%h j=%b rw=%b rd=%0d expected 28 24 1 1 1",
                     ex_result, ex_link, ex_jump, ex_reg_write, ex_rd);
        end
        drive(32'h0080006F, 32'h20, 32'd1, 32'd2, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_jump, ex_reg_write} !== {32'h28, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL jal_rd0: result=%h j=%b rw=%b expected 28 1 0",
                     ex_result, ex_jump, ex_reg_write);
        end
    endtask

    task automatic test_flush_nop();
        drive(32'h0020A423, 32'h0, 32'h100, 32'hDEAD, 1'b1, 1'b0);
        checks++;
        if ({ex_rd, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump, ex_opcode} !== '0) begin
            failures++;
            $display("FAIL flush_store: rd=%0d rw=%b ld=%b st=%b br=%b j=%b op=%h expected all 0",
                     ex_rd, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump, ex_opcode);
        end
        drive(32'h00000000, 32'h80, 32'd3, 32'd4, 1'b0, 1'b0);
        checks++;
        if ({ex_result, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump} !== '0) begin
            failures++;
            $display("FAIL nop_zero: result=%h rw=%b ld=%b st=%b br=%b j=%b expected all 0",
                     ex_result, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h00};
        for (int n = 0; n < 400; n++) begin
            logic [31:0] i, p, a, b;
            logic        fl;
            out_t        e;
            int          k;
            k = $urandom_range(0, 6);
            i = $urandom;
            i[6:0] = (k == 6) ? 7'($urandom) : ops[k];
            p = $urandom & 32'hFFFF_FFFC;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
            fl = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            instr = i; pc = p; rs1_data = a; rs2_data = b; flush = fl; rst = 1'b0;
            #1;
            checks++;
            if ({rs1_addr, rs2_addr} !== {i[19:15], i[24:20]}) begin
                failures++;
                $display("FAIL rs_addr: got %0d,%0d expected %0d,%0d",
                         rs1_addr, rs2_addr, i[19:15], i[24:20]);
            end
            e = ref_model(i, p, a, b);
            @(posedge clk);
            #1;
            checks++;
            if (fl) begin
                if ({ex_rd, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump, ex_opcode} !== '0) begin
                    failures++;
                    $display("FAIL rand_flush: instr=%h ctrl rd=%0d rw=%b ld=%b st=%b br=%b j=%b op=%h expected 0",
                             i, ex_rd, ex_reg_write, ex_load, ex_store, ex_branch_taken, ex_jump, ex_opcode);
                end
            end else if (act !== e) begin
                failures++;
                $display("FAIL rand_instr: instr=%h pc=%h a=%h b=%h got %h expected %h",
                         i, p, a, b, act, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        test_reset();
        test_alu();
        test_store();
        test_branch();
        test_jal();
        test_flush_nop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
